// File: rtl/genius_ctrl.sv
// genius_ctrl: memory-game controller that shows a growing colour sequence and checks the player's replay.
// Optional feature: define GENIUS_TIMEOUT_EN to lose the game after TIMEOUT_CYCLES idle cycles in WAIT_IN.
module genius_ctrl #(
   parameter int SHOW_CYCLES    = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] btn,
   output logic [3:0] seq_addr,
   input  logic [3:0] seq_data,
   output logic [3:0] led,
   output logic [4:0] round,
   output logic       busy,
   output logic       win,
   output logic       lose
);
   typedef enum logic [2:0] {IDLE, SHOW, GAP, WAIT_IN, PAUSE, WIN, LOSE} state_t;
   localparam int CMAX = SHOW_CYCLES > GAP_CYCLES ? SHOW_CYCLES : GAP_CYCLES;
   localparam int CW = $clog2(CMAX + 1);
   localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
   state_t state, state_n;
   logic [3:0] idx, idx_n, btn_prev;
   logic [4:0] round_n;
   logic [CW-1:0] cnt, cnt_n;
   logic press, last, match;
`ifdef GENIUS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tcnt, tcnt_n;
`endif
   assign press = (btn != 4'd0) && (btn_prev == 4'd0);
   assign match = btn == seq_data;
   assign last = {1'b0, idx} == round - 5'd1;
   assign seq_addr = idx;
   assign led = state == SHOW ? seq_data : state == WAIT_IN ? btn : state == WIN ? 4'b1111 : 4'b0000;
   assign busy = state inside {SHOW, GAP, WAIT_IN, PAUSE};
   assign win = state == WIN;
   assign lose = state == LOSE;
   // state, step index, round, phase counter and button-edge register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx <= 4'd0;
         round <= 5'd0;
         cnt <= '0;
         btn_prev <= 4'd0;
`ifdef GENIUS_TIMEOUT_EN
         tcnt <= '0;
`endif
      end else begin
         state <= state_n;
         idx <= idx_n;
         round <= round_n;
         cnt <= cnt_n;
         btn_prev <= btn;
`ifdef GENIUS_TIMEOUT_EN
         tcnt <= tcnt_n;
`endif
      end
   end
   // next-state logic: show/gap/pause timing and player answer checking
   always_comb begin
      state_n = state;
      idx_n = idx;
      round_n = round;
      cnt_n = cnt;
`ifdef GENIUS_TIMEOUT_EN
      tcnt_n = tcnt;
`endif
      case (state)
         IDLE, WIN, LOSE: begin
            if (start) begin
               state_n = SHOW;
               round_n = 5'd1;
               idx_n = 4'd0;
               cnt_n = '0;
            end
         end
         SHOW: begin
            if (cnt == SHOW_LAST) begin
               state_n = GAP;
               cnt_n = '0;
            end else cnt_n = cnt + 1'b1;
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_n = '0;
               if (last) begin
                  state_n = WAIT_IN;
                  idx_n = 4'd0;
`ifdef GENIUS_TIMEOUT_EN
                  tcnt_n = '0;
`endif
               end else begin
                  state_n = SHOW;
                  idx_n = idx + 4'd1;
               end
            end else cnt_n = cnt + 1'b1;
         end
         WAIT_IN: begin
            if (press) begin
`ifdef GENIUS_TIMEOUT_EN
               tcnt_n = '0;
`endif
               if (!match) state_n = LOSE;
               else if (!last) idx_n = idx + 4'd1;
               else if (round == 5'd16) state_n = WIN;
               else begin
                  round_n = round + 5'd1;
                  idx_n = 4'd0;
                  cnt_n = '0;
                  state_n = PAUSE;
               end
            end
`ifdef GENIUS_TIMEOUT_EN
            else if (tcnt == TO_LAST) state_n = LOSE;
            else tcnt_n = tcnt + 1'b1;
`endif
         end
         PAUSE: begin
            if (cnt == GAP_LAST) begin
               state_n = SHOW;
               idx_n = 4'd0;
               cnt_n = '0;
            end else cnt_n = cnt + 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_genius_ctrl.sv
// tb_genius_ctrl: directed self-checking bench for genius_ctrl with a small sequence ROM stub.
module tb_genius_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [3:0] btn = 4'd0;
   logic [3:0] seq_addr, seq_data, led;
   logic [4:0] round;
   logic busy, win, lose;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   genius_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .seq_addr(seq_addr),
      .seq_data(seq_data), .led(led), .round(round), .busy(busy), .win(win), .lose(lose)
   );
   function automatic logic [3:0] rom_f(input logic [3:0] a);
      case (a[1:0])
         2'd0: return 4'b0001;
         2'd1: return 4'b0100;
         2'd2: return 4'b0010;
         default: return 4'b1000;
      endcase
   endfunction
   assign seq_data = rom_f(seq_addr);
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_led"}, led, 0);
      check({tag, "_addr"}, seq_addr, 0);
      check({tag, "_round"}, round, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_win"}, win, 0);
      check({tag, "_lose"}, lose, 0);
   endtask
   task automatic start_game;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic show_all(input int n);
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < 4; c++) begin
            check("show_led", led, rom_f(4'(i)));
            check("show_busy", busy, 1);
            @(negedge clk);
         end
         for (int c = 0; c < 2; c++) begin
            check("gap_led", led, 0);
            @(negedge clk);
         end
      end
      check("wait_busy", busy, 1);
      check("wait_round", round, n);
   endtask
   task automatic press(input logic [3:0] v);
      btn = v;
      @(negedge clk);
      btn = 4'd0;
      @(negedge clk);
   endtask
   task automatic answer(input int n);
      for (int i = 0; i < n; i++) press(rom_f(4'(i)));
      if (n < 16) begin
         check("pause_round", round, n + 1);
         check("pause_led", led, 0);
         check("pause_busy", busy, 1);
         @(negedge clk);
      end
   endtask
   initial begin
      @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("idle");
      start_game;
      show_all(1);
      answer(1);
      show_all(2);
      answer(2);
      check("r3_led", led, 4'b0001);
      check("r3_round", round, 3);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("post_rst");
      start_game;
      show_all(1);
      press(4'b0100);
      check("lose", lose, 1);
      check("lose_led", led, 0);
      check("lose_busy", busy, 0);
      check("lose_round", round, 1);
      start_game;
      check("restart_round", round, 1);
      check("restart_busy", busy, 1);
      check("restart_lose", lose, 0);
      btn = 4'b0001;
      show_all(1);
      repeat (3) begin
         check("held_led", led, 4'b0001);
         check("held_round", round, 1);
         @(negedge clk);
      end
      btn = 4'd0;
      @(negedge clk);
      check("released_round", round, 1);
      answer(1);
      for (int n = 2; n <= 16; n++) begin
         show_all(n);
         answer(n);
      end
      check("win", win, 1);
      check("win_led", led, 4'b1111);
      check("win_round", round, 16);
      check("win_busy", busy, 0);
      check("win_lose", lose, 0);
`ifdef GENIUS_TIMEOUT_EN
      start_game;
      show_all(1);
      repeat (63) @(negedge clk);
      check("to_pending", lose, 0);
      @(negedge clk);
      check("to_lose", lose, 1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
